// File: rtl/axis_buf_pkg.sv
// ---------------------------------------------------------------------------
// axis_buf_pkg
// Shared types and helpers for the AXI4-Stream receive buffer.
//   beat_t       : one stored stream beat {data, keep, last} at the default
//                  32-bit data width (modules declare their own width-matched
//                  copy when DATA_W is overridden)
//   rel_state_e  : store-and-forward release FSM states {HOLD, CUT}
//   cnt_w()      : width of an occupancy counter that must hold 0..DEPTH
// ---------------------------------------------------------------------------
package axis_buf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int KEEP_W_DEF = DATA_W_DEF / 8;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic [KEEP_W_DEF-1:0] keep;
      logic                  last;
   } beat_t;

   typedef enum logic {
      HOLD = 1'b0,
      CUT  = 1'b1
   } rel_state_e;

   // One extra bit so that a completely full buffer (DEPTH) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// ---------------------------------------------------------------------------
// axis_fifo_mem
// DEPTH-entry storage array for stream beats.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : beat to store
//   raddr_i  : read address
//   rdata_o  : beat at raddr_i (asynchronous read, so the head of the buffer
//              is visible in the same cycle the read pointer moves to it)
// Contents are never reset; occupancy logic in the parent guarantees that
// unwritten entries are never presented as valid.
// ---------------------------------------------------------------------------
module axis_fifo_mem
   import axis_buf_pkg::*;
#(
   parameter type ENTRY_T = beat_t,
   parameter int  DEPTH   = 16,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  ENTRY_T        wdata_i,
   input  logic [AW-1:0] raddr_i,
   output ENTRY_T        rdata_o
);

   ENTRY_T mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_rx_buffer.sv
// ---------------------------------------------------------------------------
// axis_rx_buffer
// AXI4-Stream slave feeding a circular buffer that is re-presented on an
// AXI4-Stream master port. Optional store-and-forward release on TLAST.
//   clk, reset            : single clock, synchronous active-high reset
//   S_AXIS_T*             : input stream (TREADY driven from occupancy)
//   M_AXIS_T*             : output stream, head of buffer
//   level                 : beats currently stored (0..DEPTH)
//   pkt_count             : TLAST beats currently stored
// Parameters: DATA_W (multiple of 8), DEPTH (power of two, >= 2),
//   PACKET_MODE (0 = cut-through, 1 = release only complete packets).
// ---------------------------------------------------------------------------
module axis_rx_buffer
   import axis_buf_pkg::*;
#(
   parameter int  DATA_W      = 32,
   parameter int  DEPTH       = 16,
   parameter int  PACKET_MODE = 0,
   localparam int KEEP_W      = DATA_W / 8,
   localparam int CNT_W       = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              S_AXIS_TVALID,
   output logic              S_AXIS_TREADY,
   input  logic [DATA_W-1:0] S_AXIS_TDATA,
   input  logic [KEEP_W-1:0] S_AXIS_TKEEP,
   input  logic              S_AXIS_TLAST,
   output logic              M_AXIS_TVALID,
   input  logic              M_AXIS_TREADY,
   output logic [DATA_W-1:0] M_AXIS_TDATA,
   output logic [KEEP_W-1:0] M_AXIS_TKEEP,
   output logic              M_AXIS_TLAST,
   output logic [CNT_W-1:0]  level,
   output logic [CNT_W-1:0]  pkt_count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } rx_beat_t;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] pkt_q, pkt_d;
   logic             s_ready_q, s_ready_d;
   logic             m_valid_q, m_valid_d;
   rel_state_e       state_q, state_d;

   rx_beat_t wr_beat;
   rx_beat_t rd_beat;
   logic     wr_en;
   logic     rd_en;
   logic     pkt_inc;
   logic     pkt_dec;

   assign wr_beat = '{data: S_AXIS_TDATA, keep: S_AXIS_TKEEP, last: S_AXIS_TLAST};

   // Both handshakes depend only on registered ready/valid, so a read in the
   // same cycle never frees space for a write while full.
   assign wr_en   = S_AXIS_TVALID && s_ready_q;
   assign rd_en   = m_valid_q && M_AXIS_TREADY;
   assign pkt_inc = wr_en && S_AXIS_TLAST;
   assign pkt_dec = rd_en && rd_beat.last;

   axis_fifo_mem #(
      .ENTRY_T (rx_beat_t),
      .DEPTH   (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_beat),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_beat)
   );

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      level_d = level_q;
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + CNT_W'(1);
         2'b01:   level_d = level_q - CNT_W'(1);
         default: level_d = level_q;
      endcase

      pkt_d = pkt_q;
      case ({pkt_inc, pkt_dec})
         2'b10:   pkt_d = pkt_q + CNT_W'(1);
         2'b01:   pkt_d = pkt_q - CNT_W'(1);
         default: pkt_d = pkt_q;
      endcase

      // Release FSM. A full buffer holding no TLAST can never complete its
      // packet, so it is released cut-through until that packet's TLAST leaves.
      state_d = state_q;
      case (state_q)
         HOLD: if ((PACKET_MODE != 0) && (level_q == FULL_LVL) && (pkt_q == '0))
                  state_d = CUT;
         CUT:  if (rd_en && rd_beat.last)
                  state_d = HOLD;
         default: state_d = HOLD;
      endcase

      // Valid is computed from next-state values and registered, which keeps
      // it equal to the occupancy rule applied to the registered state.
      if (PACKET_MODE == 0) begin
         m_valid_d = (level_d != '0);
      end else if (state_d == HOLD) begin
         m_valid_d = (pkt_d != '0);
      end else begin
         m_valid_d = (level_d != '0);
      end

      s_ready_d = (level_d != FULL_LVL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         pkt_q     <= '0;
         state_q   <= HOLD;
         m_valid_q <= 1'b0;
         s_ready_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         pkt_q     <= pkt_d;
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         s_ready_q <= s_ready_d;
      end
   end

   assign S_AXIS_TREADY = s_ready_q;
   assign M_AXIS_TVALID = m_valid_q;
   assign M_AXIS_TDATA  = rd_beat.data;
   assign M_AXIS_TKEEP  = rd_beat.keep;
   assign M_AXIS_TLAST  = rd_beat.last;
   assign level         = level_q;
   assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_axis_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_axis_rx_buffer
// Two instances: u_dut0 cut-through (DEPTH 16) and u_dut1 store-and-forward
// (DEPTH 8). Accepted input beats are pushed to per-instance queues and
// popped/compared when the output handshake occurs.
// ---------------------------------------------------------------------------
module tb_axis_rx_buffer;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } sb_t;

   logic        clk;
   logic        rst;

   logic        s_tvalid0, s_tready0, s_tlast0, m_tvalid0, m_tready0, m_tlast0;
   logic [31:0] s_tdata0, m_tdata0;
   logic [3:0]  s_tkeep0, m_tkeep0;
   logic [4:0]  level0, pkt0;

   logic        s_tvalid1, s_tready1, s_tlast1, m_tvalid1, m_tready1, m_tlast1;
   logic [31:0] s_tdata1, m_tdata1;
   logic [3:0]  s_tkeep1, m_tkeep1;
   logic [3:0]  level1, pkt1;

   int  tests = 0;
   int  fails = 0;
   sb_t q0[$];
   sb_t q1[$];

   int  acc0, acc1, cyc, n;
   logic a0, a1, fast;

   axis_rx_buffer #(.DATA_W(32), .DEPTH(16), .PACKET_MODE(0)) u_dut0 (
      .clk(clk), .reset(rst),
      .S_AXIS_TVALID(s_tvalid0), .S_AXIS_TREADY(s_tready0), .S_AXIS_TDATA(s_tdata0),
      .S_AXIS_TKEEP(s_tkeep0), .S_AXIS_TLAST(s_tlast0),
      .M_AXIS_TVALID(m_tvalid0), .M_AXIS_TREADY(m_tready0), .M_AXIS_TDATA(m_tdata0),
      .M_AXIS_TKEEP(m_tkeep0), .M_AXIS_TLAST(m_tlast0),
      .level(level0), .pkt_count(pkt0)
   );

   axis_rx_buffer #(.DATA_W(32), .DEPTH(8), .PACKET_MODE(1)) u_dut1 (
      .clk(clk), .reset(rst),
      .S_AXIS_TVALID(s_tvalid1), .S_AXIS_TREADY(s_tready1), .S_AXIS_TDATA(s_tdata1),
      .S_AXIS_TKEEP(s_tkeep1), .S_AXIS_TLAST(s_tlast1),
      .M_AXIS_TVALID(m_tvalid1), .M_AXIS_TREADY(m_tready1), .M_AXIS_TDATA(m_tdata1),
      .M_AXIS_TKEEP(m_tkeep1), .M_AXIS_TLAST(m_tlast1),
      .level(level1), .pkt_count(pkt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [31:0] d, input logic l);
      int w;
      w = 0;
      s_tvalid1 = 1'b1;
      s_tdata1  = d;
      s_tkeep1  = 4'hF;
      s_tlast1  = l;
      while (!s_tready1 && w < 50) begin
         step();
         w++;
      end
      chk("send1_ready", 64'(s_tready1), 64'd1);
      step();
      s_tvalid1 = 1'b0;
   endtask

   // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that
   // completes them.
   always @(negedge clk) begin
      sb_t e;
      if (!rst) begin
         if (s_tvalid0 && s_tready0) q0.push_back(sb_t'{s_tdata0, s_tkeep0, s_tlast0});
         if (s_tvalid1 && s_tready1) q1.push_back(sb_t'{s_tdata1, s_tkeep1, s_tlast1});
         if (m_tvalid0 && m_tready0) begin
            if (q0.size() == 0) chk("dut0_unexpected_beat", 64'd1, 64'd0);
            else begin
               e = q0.pop_front();
               chk("dut0_beat", 64'({m_tdata0, m_tkeep0, m_tlast0}), 64'(e));
               $display("[TB] dut0 out data=%h keep=%h last=%0d", m_tdata0, m_tkeep0, m_tlast0);
            end
         end
         if (m_tvalid1 && m_tready1) begin
            if (q1.size() == 0) chk("dut1_unexpected_beat", 64'd1, 64'd0);
            else begin
               e = q1.pop_front();
               chk("dut1_beat", 64'({m_tdata1, m_tkeep1, m_tlast1}), 64'(e));
               $display("[TB] dut1 out data=%h keep=%h last=%0d", m_tdata1, m_tkeep1, m_tlast1);
            end
         end
         chk("dut0_level_le_depth", 64'(level0 <= 5'd16), 64'd1);
         chk("dut1_level_le_depth", 64'(level1 <= 4'd8), 64'd1);
      end
   end

   initial begin
      rst = 1'b1;
      s_tvalid0 = 0; s_tdata0 = '0; s_tkeep0 = '0; s_tlast0 = 0; m_tready0 = 0;
      s_tvalid1 = 0; s_tdata1 = '0; s_tkeep1 = '0; s_tlast1 = 0; m_tready1 = 0;

      // ---- reset state ----
      repeat (3) step();
      chk("rst_tready0", 64'(s_tready0), 64'd0);
      chk("rst_level0", 64'(level0), 64'd0);
      chk("rst_pkt0", 64'(pkt0), 64'd0);
      chk("rst_mvalid0", 64'(m_tvalid0), 64'd0);
      chk("rst_mvalid1", 64'(m_tvalid1), 64'd0);
      rst = 1'b0;
      step();
      chk("post_rst_tready0", 64'(s_tready0), 64'd1);
      chk("post_rst_tready1", 64'(s_tready1), 64'd1);

      // ---- mode 0: five single beats, consumer always ready ----
      m_tready0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_tvalid0 = 1'b1;
         s_tdata0  = 32'h11 + 32'(i);
         s_tkeep0  = 4'hF;
         s_tlast0  = (i == 4);
         if (i == 0) chk("no_bypass_mvalid0", 64'(m_tvalid0), 64'd0);
         step();
         chk("t1_mvalid0", 64'(m_tvalid0), 64'd1);
         chk("t1_mdata0", 64'(m_tdata0), 64'h11 + 64'(i));
      end
      s_tvalid0 = 1'b0;
      step();
      chk("t1_level0_empty", 64'(level0), 64'd0);
      chk("t1_mvalid0_empty", 64'(m_tvalid0), 64'd0);

      // ---- mode 0: fill to 16 with consumer stalled ----
      m_tready0 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_tvalid0 = 1'b1;
         s_tdata0  = 32'hA000_0000 + 32'(i);
         s_tkeep0  = 4'(i);
         s_tlast0  = (i % 5 == 4);
         step();
      end
      chk("t2_level0_full", 64'(level0), 64'd16);
      chk("t2_tready0_full", 64'(s_tready0), 64'd0);
      s_tdata0 = 32'hA000_0017; s_tkeep0 = 4'h3; s_tlast0 = 1'b1;
      step();
      step();
      chk("t2_level0_held", 64'(level0), 64'd16);
      chk("t2_tready0_held", 64'(s_tready0), 64'd0);
      m_tready0 = 1'b1;
      step();
      m_tready0 = 1'b0;
      chk("t2_tready0_after_read", 64'(s_tready0), 64'd1);
      chk("t2_level0_after_read", 64'(level0), 64'd15);
      step();
      s_tvalid0 = 1'b0;
      chk("t2_level0_refill", 64'(level0), 64'd16);
      m_tready0 = 1'b1;
      repeat (16) step();
      chk("t2_level0_drained", 64'(level0), 64'd0);
      chk("t2_pkt0_drained", 64'(pkt0), 64'd0);

      // ---- mode 1: 4-beat packet ----
      m_tready1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_tvalid1 = 1'b1;
         s_tdata1  = 32'hB0 + 32'(i);
         s_tkeep1  = 4'hF;
         s_tlast1  = (i == 3);
         step();
         chk("t3_mvalid1", 64'(m_tvalid1), (i == 3) ? 64'd1 : 64'd0);
         chk("t3_pkt1", 64'(pkt1), (i == 3) ? 64'd1 : 64'd0);
      end
      s_tvalid1 = 1'b0;
      repeat (4) step();
      chk("t3_pkt1_done", 64'(pkt1), 64'd0);
      chk("t3_level1_done", 64'(level1), 64'd0);
      chk("t3_mvalid1_done", 64'(m_tvalid1), 64'd0);

      // ---- mode 1: 12-beat oversize packet into DEPTH 8 ----
      m_tready1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_tvalid1 = 1'b1;
         s_tdata1  = 32'hC00 + 32'(i);
         s_tkeep1  = 4'(i + 1);
         s_tlast1  = 1'b0;
         step();
      end
      s_tvalid1 = 1'b0;
      chk("t4_level1_full", 64'(level1), 64'd8);
      chk("t4_tready1_full", 64'(s_tready1), 64'd0);
      chk("t4_mvalid1_hold", 64'(m_tvalid1), 64'd0);
      step();
      chk("t4_mvalid1_cut", 64'(m_tvalid1), 64'd1);
      m_tready1 = 1'b1;
      for (int i = 8; i < 12; i++) send1(32'hC00 + 32'(i), i == 11);
      n = 0;
      while (level1 != 0 && n < 40) begin step(); n++; end
      chk("t4_level1_drained", 64'(level1), 64'd0);
      chk("t4_mvalid1_drained", 64'(m_tvalid1), 64'd0);
      send1(32'hD0, 1'b0);
      chk("t4_back_in_hold", 64'(m_tvalid1), 64'd0);
      send1(32'hD1, 1'b1);
      chk("t4_hold_release", 64'(m_tvalid1), 64'd1);
      repeat (2) step();
      chk("t4_level1_end", 64'(level1), 64'd0);

      // ---- reset with beats stored ----
      m_tready0 = 1'b0;
      m_tready1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_tvalid0 = 1'b1; s_tdata0 = 32'hE0 + 32'(i); s_tkeep0 = 4'hF; s_tlast0 = (i == 2);
         s_tvalid1 = 1'b1; s_tdata1 = 32'hF0 + 32'(i); s_tkeep1 = 4'hF; s_tlast1 = 1'b0;
         step();
      end
      s_tvalid0 = 1'b0;
      s_tvalid1 = 1'b0;
      chk("t5_level0_before", 64'(level0), 64'd3);
      rst = 1'b1;
      step();
      q0.delete();
      q1.delete();
      chk("t5_level0_rst", 64'(level0), 64'd0);
      chk("t5_pkt0_rst", 64'(pkt0), 64'd0);
      chk("t5_mvalid0_rst", 64'(m_tvalid0), 64'd0);
      chk("t5_tready0_rst", 64'(s_tready0), 64'd0);
      chk("t5_level1_rst", 64'(level1), 64'd0);
      rst = 1'b0;
      m_tready0 = 1'b1;
      m_tready1 = 1'b1;
      step();
      chk("t5_tready0_after", 64'(s_tready0), 64'd1);
      chk("t5_tready1_after", 64'(s_tready1), 64'd1);
      step();
      chk("t5_no_stale0", 64'(m_tvalid0), 64'd0);
      chk("t5_no_stale1", 64'(m_tvalid1), 64'd0);

      // ---- random traffic, 1000 beats per instance ----
      acc0 = 0; acc1 = 0; cyc = 0;
      while ((acc0 < 1000 || acc1 < 1000) && cyc < 20000) begin
         fast = ((cyc / 256) % 2) == 0;
         m_tready0 = fast ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         m_tready1 = fast ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         if (!s_tvalid0 && acc0 < 1000 && $urandom_range(0, 3) != 0) begin
            s_tvalid0 = 1'b1;
            s_tdata0  = $urandom;
            s_tkeep0  = 4'($urandom);
            s_tlast0  = ($urandom_range(0, 3) == 0);
         end
         if (!s_tvalid1 && acc1 < 1000 && $urandom_range(0, 3) != 0) begin
            s_tvalid1 = 1'b1;
            s_tdata1  = $urandom;
            s_tkeep1  = 4'($urandom);
            s_tlast1  = ($urandom_range(0, 5) == 0);
         end
         a0 = s_tvalid0 && s_tready0;
         a1 = s_tvalid1 && s_tready1;
         step();
         cyc++;
         if (a0) begin acc0++; s_tvalid0 = 1'b0; end
         if (a1) begin acc1++; s_tvalid1 = 1'b0; end
      end
      chk("rand_accepted0", 64'(acc0), 64'd1000);
      chk("rand_accepted1", 64'(acc1), 64'd1000);
      m_tready0 = 1'b1;
      m_tready1 = 1'b1;
      send1(32'h5A5A_0001, 1'b1);
      n = 0;
      while ((level0 != 0 || level1 != 0) && n < 200) begin step(); n++; end
      chk("rand_level0_end", 64'(level0), 64'd0);
      chk("rand_level1_end", 64'(level1), 64'd0);
      chk("rand_q0_empty", 64'(q0.size()), 64'd0);
      chk("rand_q1_empty", 64'(q1.size()), 64'd0);
      chk("rand_pkt1_end", 64'(pkt1), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
